// File: rtl/matvec_mac_sequencer.sv
// Time-multiplexed matrix-times-vector: one shared MAC walks the i index for each column j
// and streams result[j] out over a valid/ready handshake. States: IDLE load/wait, RUN accumulate, OUT present result.
module matvec_mac_sequencer #(
  parameter int ROWS = 3,
  parameter int COLS = 5,
  parameter int W    = 32,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_idx,
  output logic          done
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  mat [ROWS][COLS];
  logic [W-1:0]  vec [ROWS];
  logic [RW-1:0] i;
  logic [CW-1:0] j;
  logic [W-1:0]  acc;
  logic [W-1:0]  prod;
  logic          last_row;
  logic          last_col;
  logic          hs;

  // Low W bits of the product are identical for signed and unsigned operands.
  assign prod     = mat[i][j] * vec[i];
  assign last_row = (i == ROW_LAST);
  assign last_col = (j == COL_LAST);
  assign hs       = (state == OUT) && out_ready;

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    out_valid  = (state == OUT);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_row) state_next = OUT;
      OUT:     if (out_ready) state_next = last_col ? IDLE : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        vec[r] <= '0;
        for (int c = 0; c < COLS; c++) mat[r][c] <= '0;
      end
      i        <= '0;
      j        <= '0;
      acc      <= '0;
      out_data <= '0;
      out_idx  <= '0;
      done     <= 1'b0;
    end else begin
      done <= hs && last_col;
      if (state == IDLE && wr_en && wr_row <= ROW_LAST) begin
        if (wr_sel)                   vec[wr_row]         <= wr_data;
        else if (wr_col <= COL_LAST)  mat[wr_row][wr_col] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (start) begin
            i   <= '0;
            j   <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          if (last_row) begin
            out_data <= acc + prod;
            out_idx  <= j;
          end else begin
            acc <= acc + prod;
            i   <= i + 1'b1;
          end
        end
        OUT: begin
          if (out_ready && !last_col) begin
            j   <= j + 1'b1;
            i   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_mac_sequencer.sv
// Bench for matvec_mac_sequencer: directed table cases, backpressure, busy-time writes,
// mid-run reset and randomized operands checked against a plain-arithmetic reference.
module tb_matvec_mac_sequencer;
  localparam int ROWS = 3;
  localparam int COLS = 5;
  localparam int W    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic          wr_sel;
  logic [1:0]    wr_row;
  logic [2:0]    wr_col;
  logic [W-1:0]  wr_data;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_idx;
  logic          done;

  matvec_mac_sequencer #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0][W-1:0]            vec;
    logic [ROWS-1:0][COLS-1:0][W-1:0]  mat;
    logic [COLS-1:0][W-1:0]            expv;
  } case_t;

  case_t        cases [3];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] m_mat [ROWS][COLS];
  logic [W-1:0] m_vec [ROWS];
  logic [W-1:0] exp_res [COLS];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      m_vec[r] = '0;
      for (int c = 0; c < COLS; c++) m_mat[r][c] = '0;
    end
  endtask

  // result[j] = sum_i matrix[i][j]*vector[i], modulo 2^W
  task automatic model_compute();
    for (int c = 0; c < COLS; c++) begin
      logic [W-1:0] s;
      s = '0;
      for (int r = 0; r < ROWS; r++) s = s + W'(m_mat[r][c] * m_vec[r]);
      exp_res[c] = s;
    end
  endtask

  task automatic wr_op(input logic sel, input int row, input int col, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_col = 3'(col); wr_data = d;
    step();
    wr_en = 1'b0;
    if (row < ROWS) begin
      if (sel)             m_vec[row] = d;
      else if (col < COLS) m_mat[row][col] = d;
    end
  endtask

  task automatic load_case(input int k);
    for (int r = 0; r < ROWS; r++) wr_op(1'b1, r, 0, cases[k].vec[r]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wr_op(1'b0, r, c, cases[k].mat[r][c]);
    for (int c = 0; c < COLS; c++) exp_res[c] = cases[k].expv[c];
  endtask

  // Starts a run and checks every result, its timing, busy and the done pulse.
  task automatic run_check(input int stall_j, input int stall_n, input bit poke,
                           input bit sw, input logic [W-1:0] sw_data);
    int cyc;
    int k;
    int busy_end;
    if (sw) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 3'd2; wr_data = sw_data;
    end
    start = 1'b1;
    step();
    start = 1'b0; wr_en = 1'b0;
    cyc = 1;
    chk1("busy_after_start", busy, 1'b1);
    if (poke) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 3'd0; wr_data = 32'd99; start = 1'b1;
      step();
      cyc++;
      wr_en = 1'b0; start = 1'b0;
    end
    busy_end = 0;
    for (int jj = 0; jj < COLS; jj++) begin
      k = 0;
      while (!out_valid && k < 40) begin
        step();
        cyc++;
        k++;
      end
      if (!out_valid) begin
        chk1("valid_timeout", out_valid, 1'b1);
        return;
      end
      chk("valid_cycle", cyc, (jj + 1) * (ROWS + 1) + ((jj > stall_j) ? stall_n : 0));
      chk("out_data", out_data, exp_res[jj]);
      chk("out_idx", {29'd0, out_idx}, jj);
      chk1("busy_in_run", busy, 1'b1);
      chk1("no_early_done", done, 1'b0);
      if (jj == stall_j) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          step();
          cyc++;
          chk1("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, exp_res[jj]);
          chk("stall_idx", {29'd0, out_idx}, jj);
        end
        out_ready = 1'b1;
      end
      busy_end = cyc;
      step();
      cyc++;
      if (jj < COLS - 1) chk1("valid_drop", out_valid, 1'b0);
    end
    chk("busy_cycles", busy_end, COLS * (ROWS + 1) + stall_n);
    chk1("busy_end", busy, 1'b0);
    chk1("done_pulse", done, 1'b1);
    step();
    chk1("done_clear", done, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) cases[k] = '0;
    for (int r = 0; r < ROWS; r++) begin
      cases[0].vec[r] = W'(r + 1);
      for (int c = 0; c < COLS; c++) cases[0].mat[r][c] = W'(c + 1);
    end
    cases[0].expv = {32'd30, 32'd24, 32'd18, 32'd12, 32'd6};
    cases[1].mat[0][0] = -32'sd2;
    cases[1].vec[0]    = 32'd7;
    cases[1].mat[2][0] = 32'd3;
    cases[1].vec[2]    = -32'sd1;
    cases[1].expv      = {32'd0, 32'd0, 32'd0, 32'd0, -32'sd17};
    cases[2].mat[0][1] = 32'h0001_0000;
    cases[2].vec[0]    = 32'h0001_0000;
    cases[2].vec[1]    = 32'h7FFF_FFFF;
    cases[2].mat[1][1] = 32'd1;
    cases[2].expv      = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd0};

    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    start = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (3) step();
    rst_n = 1'b1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_idx", {29'd0, out_idx}, 32'd0);
    chk1("rst_done", done, 1'b0);

    for (int k = 0; k < 3; k++) begin
      load_case(k);
      run_check(-1, 0, 1'b0, 1'b0, '0);
    end

    load_case(0);
    run_check(2, 5, 1'b0, 1'b0, '0);
    run_check(-1, 0, 1'b1, 1'b0, '0);
    run_check(-1, 0, 1'b0, 1'b0, '0);

    for (int it = 0; it < 4; it++) begin
      logic [W-1:0] d;
      for (int n = 0; n < 12; n++)
        wr_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), $urandom);
      d = $urandom;
      if (it == 3) m_mat[1][2] = d;
      model_compute();
      if ($urandom_range(0, 1) == 1)
        run_check($urandom_range(0, 4), $urandom_range(1, 3), 1'b0, it == 3, d);
      else
        run_check(-1, 0, 1'b0, it == 3, d);
    end

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    rst_n = 1'b0;
    step();
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_idx", {29'd0, out_idx}, 32'd0);
    chk1("midrst_done", done, 1'b0);
    rst_n = 1'b1;
    model_clear();
    for (int n = 0; n < 3; n++) begin
      step();
      chk1("midrst_no_done", done, 1'b0);
    end
    model_compute();
    run_check(-1, 0, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matvec_mac_sequencer.md
# matvec_mac_sequencer

Sequential controller that computes `result[j] = sum over i of matrix[i][j] * vector[i]` using one shared 32-bit signed multiply-accumulate unit instead of ROWS×COLS parallel multipliers. The host loads operands through a write port, pulses `start`, and receives the COLS results in index order over a valid/ready stream. It sits between the host register interface and downstream consumers, and is the area-reduced alternative to the fully combinational matrix-times-vector datapath.

## Interface
- ROWS, 3: vector length; number of matrix rows (i index).
- COLS, 5: result length; number of matrix columns (j index).
- W, 32: data width; all operands and results are signed W-bit.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = matrix, 1 = vector.
- wr_row  in  $clog2(ROWS)  i index (matrix row, or vector index).
- wr_col  in  $clog2(COLS)  j index; ignored when wr_sel=1.
- wr_data  in  W  signed operand.
- start  in  1  begin a computation; single-cycle pulse or level.
- busy  out  1  high from the cycle after accepted start until the final result handshake completes.
- out_valid  out  1  out_data/out_idx hold a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  W  signed result[j].
- out_idx  out  $clog2(COLS)  j of the current result.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- Storage: ROWS×COLS matrix register file and ROWS vector register file. All entries reset to 0.
- Writes take effect only in IDLE. Writes while busy are ignored.
- Out-of-range addresses (row ≥ ROWS, col ≥ COLS) are ignored.
- FSM:
  - IDLE: start=1 → RUN with j=0, i=0, acc=0.
  - RUN: each cycle does acc += matrix[i][j]*vector[i] and increments i. At i=ROWS-1 the final sum is registered into out_data, out_idx=j → OUT.
  - OUT: out_valid=1. On out_valid&&out_ready:
    - if j<COLS-1 → RUN with j+1, i=0, acc=0;
    - else → IDLE and assert done for one cycle.
- Arithmetic: the product is truncated to its low W bits and the accumulation wraps modulo 2^W (two's complement). There is no saturation and no overflow flag; this matches the combinational datapath bit-for-bit.
- start is ignored outside IDLE. start and wr_en in the same IDLE cycle: the write commits, and the run uses the new value.
- Reset: synchronous and active-low. It overrides everything in any state, including mid-RUN or mid-OUT. The FSM returns to IDLE, the register files clear, and no done pulse is produced.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_idx=0, done=0.
- start sampled high at edge N (IDLE):
  - busy=1 from N+1;
  - RUN occupies cycles N+1 .. N+ROWS;
  - out_valid=1 from cycle N+ROWS+1.
- Per-result latency is ROWS+1 cycles from entering RUN to out_valid. With out_ready tied high, a full run takes COLS×(ROWS+1) cycles; default 20.
- out_valid does not drop and out_data/out_idx do not change until the handshake completes.
- After a handshake, out_valid=0 for ROWS cycles (the next RUN phase).
- The last handshake at edge M gives busy=0 and done=1 in cycle M+1, and done=0 in cycle M+2. A new start is accepted at edge M+1.

## Test plan
- Load vector (1,2,3) and matrix[i][j]=j+1 for all i; start with out_ready=1 → results 6,12,18,24,30 on out_idx 0..4, each out_valid exactly 4 cycles apart, single done pulse, busy high for 20 cycles.
- Negative values: matrix[0][0]=-2, vector[0]=7, matrix[2][0]=3, vector[2]=-1, all other entries 0 → result[0]=-17, results 1..4 = 0.
- Wrap-around: matrix[0][1]=0x00010000, vector[0]=0x00010000, vector[1]=0x7FFFFFFF, matrix[1][1]=1 → result[1]=0x7FFFFFFF (the first product truncates to 0).
- Backpressure: hold out_ready=0 for 5 cycles on result 2 → out_valid, out_data and out_idx stay stable; the sequence resumes correctly; total run length grows by exactly 5 cycles.
- Writes and start while busy: write matrix[0][0]=99 and pulse start mid-run → results match the pre-run operands; no restart occurs; the next run observes unchanged storage.
- Reset mid-run: assert rst_n=0 during RUN of j=3 → next cycle busy=0, out_valid=0, out_idx=0, out_data=0, done never pulses; a later run with zeroed storage returns five zeros.
